// File: rtl/serial_nibble_adder.sv
// serial_nibble_adder: adds two W-bit operands (W = 4*NIB) one nibble per clock, LSB
// nibble first, carrying between nibbles through a single carry register.
//
// Ports:
//   clk   - clock; all state changes on its rising edge
//   rst   - synchronous active-high reset; takes priority over start
//   start - request an addition; accepted only while busy is low
//   a, b  - operands, captured on the accepting edge
//   cin   - carry-in, captured on the accepting edge
//   sum   - registered (a + b + cin) mod 2^W; held until the next result completes
//   cout  - registered carry out of bit W-1
//   ovf   - registered two's-complement signed overflow
//   busy  - high for the NIB cycles of computation
//   done  - one-cycle pulse; sum/cout/ovf are valid in that cycle
//
// Timing: start sampled at edge k gives busy after edges k..k+NIB-1 and done after
// edge k+NIB. A start in the done cycle is accepted, so results can stream every
// NIB+1 cycles.
module serial_nibble_adder #(
  parameter int unsigned NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*NIB-1:0]   a,
  input  logic [4*NIB-1:0]   b,
  input  logic               cin,
  output logic [4*NIB-1:0]   sum,
  output logic               cout,
  output logic               ovf,
  output logic               busy,
  output logic               done
);

  localparam int unsigned W    = 4 * NIB;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;       // operand A, shifted right one nibble per RUN cycle
  logic [W-1:0]    b_q;       // operand B, shifted right one nibble per RUN cycle
  logic [W-1:0]    acc_q;     // result shift register, filled from the top
  logic            carry_q;
  logic [IdxW-1:0] idx_q;
  logic            a_msb_q;   // sign bits of the original operands, kept for ovf
  logic            b_msb_q;

  logic [4:0]      nib_sum;
  logic [W-1:0]    acc_next;

  always_comb begin
    nib_sum  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
    // New nibble enters at the top; after NIB shifts the LSB nibble sits at the bottom.
    acc_next = (acc_q >> 4) | (W'(nib_sum[3:0]) << (W - 4));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            a_msb_q <= a[W-1];
            b_msb_q <= b[W-1];
            carry_q <= cin;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          acc_q   <= acc_next;
          carry_q <= nib_sum[4];
          idx_q   <= idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            // Final nibble: publish the full result; nothing intermediate reaches sum.
            sum     <= acc_next;
            cout    <= nib_sum[4];
            ovf     <= (a_msb_q == b_msb_q) && (nib_sum[3] != a_msb_q);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Bench for serial_nibble_adder (NIB=4): directed literal cases plus randomized
// traffic, all checked every cycle against a timeline/arithmetic reference model.
module tb_serial_nibble_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_nibble_adder #(.NIB(NIB)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a timeline of accepted requests. An accepted request at edge c
  // completes at edge c+NIB with the arithmetic result of the captured operands.
  longint       cyc = 0;
  longint       done_edge = 0;
  bit           pending = 0;
  bit           live = 0;
  bit           accept;
  logic [W:0]   pend_res;
  bit           pend_ovf;
  longint       sres;
  logic [W-1:0] m_sum;
  bit           m_cout, m_ovf, m_busy, m_done;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pending = 0;
      m_sum   = '0;
      m_cout  = 0;
      m_ovf   = 0;
      m_busy  = 0;
      m_done  = 0;
      live    = 1;
    end else begin
      accept = start && !m_busy;
      m_done = pending && (cyc == done_edge);
      if (m_done) begin
        m_sum   = pend_res[W-1:0];
        m_cout  = pend_res[W];
        m_ovf   = pend_ovf;
        pending = 0;
      end
      if (accept) begin
        pending   = 1;
        done_edge = cyc + NIB;
        pend_res  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sres      = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        pend_ovf  = (sres > SMAX) || (sres < SMIN);
      end
      m_busy = pending && (cyc < done_edge);
    end
    if (live) begin
      #1;
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
      check("model_sum", sum, m_sum);
      check("model_cout", cout, m_cout);
      check("model_ovf", ovf, m_ovf);
    end
  end

  // Drive one start pulse, then scramble the inputs to show they are not reused.
  // Returns at the falling edge after the accepting edge.
  task automatic pulse_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Wait (bounded) until done is seen at a falling edge; count busy cycles on the way.
  task automatic wait_done(output int waited, output int busy_cnt);
    waited   = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && waited < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic directed(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic [W-1:0] es, input logic ec,
                          input logic eo);
    int w, bc;
    pulse_start(av, bv, cv);
    wait_done(w, bc);
    check({name, "_latency"}, 64'(w), 64'(NIB));
    check({name, "_busy_cycles"}, 64'(bc), 64'(NIB));
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, cout, ec);
    check({name, "_ovf"}, ovf, eo);
    @(negedge clk);
    check({name, "_done_one_cycle"}, done, 1'b0);
    check({name, "_sum_hold"}, sum, es);
  endtask

  initial begin
    int w, bc, pulses;
    logic [W-1:0] seen_sum;
    logic [W-1:0] ra, rb;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_sum", sum, 16'h0000);
    check("reset_cout", cout, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    directed("basic",     16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed("nib_carry", 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0);
    directed("full_wrap", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    directed("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("neg_ovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Start while busy is ignored.
    pulse_start(16'h0001, 16'h0001, 1'b0);
    pulse_start(16'hFFFF, 16'hFFFF, 1'b0);
    pulses   = 0;
    seen_sum = 'x;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        pulses++;
        seen_sum = sum;
      end
      @(negedge clk);
    end
    check("ignored_start_pulses", 64'(pulses), 64'd1);
    check("ignored_start_sum", seen_sum, 16'h0002);
    check("ignored_start_cout", cout, 1'b0);

    // Back-to-back: second start in the done cycle of the first.
    pulse_start(16'h1111, 16'h2222, 1'b1);
    wait_done(w, bc);
    check("b2b_first_sum", sum, 16'h3334);
    start = 1'b1;
    a     = 16'hF000;
    b     = 16'h1000;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(w, bc);
    check("b2b_spacing", 64'(w + 1), 64'd5);
    check("b2b_second_sum", sum, 16'h0000);
    check("b2b_second_cout", cout, 1'b1);
    @(negedge clk);

    // Reset in the second RUN cycle aborts the computation.
    pulse_start(16'h0005, 16'h0006, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 16'h0000);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    check("abort_sum_held", sum, 16'h0000);
    directed("after_abort", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Randomized traffic; the every-cycle model comparison does the checking.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 5))
        0: ra = 16'h0000;
        1: ra = 16'hFFFF;
        2: ra = 16'h7FFF;
        3: ra = 16'h8000;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: rb = 16'h0000;
        1: rb = 16'hFFFF;
        2: rb = 16'h0001;
        3: rb = 16'h8000;
        default: rb = W'($urandom);
      endcase
      a     = ra;
      b     = rb;
      cin   = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_nibble_adder.md
SERIAL_NIBBLE_ADDER -- requirements
Module: serial_nibble_adder

Parameters
REQ-001 The block SHALL have parameter NIB, default 4, meaning the number of 4-bit nibbles per operand; operand width W = 4*NIB, and NIB >= 1.

Interface
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  input  1  SHALL request an addition; it is accepted only when busy=0.
REQ-005 a  input  W  SHALL be operand A, sampled on the accepting edge.
REQ-006 b  input  W  SHALL be operand B, sampled on the accepting edge.
REQ-007 cin  input  1  SHALL be the carry-in, sampled on the accepting edge.
REQ-008 sum  output  W  SHALL be the registered result, (A+B+cin) mod 2^W.
REQ-009 cout  output  1  SHALL be the registered carry out of bit W-1.
REQ-010 ovf  output  1  SHALL be the registered two's-complement signed overflow.
REQ-011 busy  output  1  SHALL be high while the block is computing.
REQ-012 done  output  1  SHALL be a one-cycle pulse marking that sum, cout and ovf are valid.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after NIB RUN cycles.
  - DONE -> RUN if start=1, else DONE -> IDLE.
REQ-014 On the accepting edge the block SHALL:
  - capture a, b and cin into internal registers;
  - clear the nibble index;
  - load the carry register with cin.
REQ-015 Each RUN cycle SHALL process one nibble, LSB nibble first:
  - compute the 5-bit value a_nib + b_nib + carry;
  - shift the low 4 bits into the result shift register;
  - write the bit-4 carry back to the carry register;
  - increment the nibble index.
REQ-016 On the final RUN edge the block SHALL update sum, cout and ovf.
  - ovf = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]).
REQ-017 Latency SHALL be fixed:
  - start sampled at edge k;
  - busy=1 for the cycles following edges k through k+NIB-1;
  - done=1 for exactly one cycle following edge k+NIB;
  - sum, cout and ovf are valid in that same cycle.
REQ-018 busy SHALL be low in IDLE and DONE, and done SHALL be low in IDLE and RUN.
REQ-019 start asserted while busy=1 SHALL be ignored, with no effect on operands, progress or outputs.
REQ-020 start asserted in the DONE cycle SHALL be accepted, with done still pulsing in that cycle.
REQ-021 sum, cout and ovf SHALL hold their values from the DONE edge until the next computation completes.
  - They do not change during RUN.
  - Intermediate nibbles are never visible on sum.
REQ-022 Carry SHALL propagate across every nibble boundary; no carry or borrow is dropped.
REQ-023 a, b and cin changing during RUN SHALL NOT affect the result.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL:
  - enter IDLE;
  - set sum=0, cout=0, ovf=0, busy=0, done=0;
  - clear the carry register and nibble index.
REQ-025 rst SHALL have priority over start.
REQ-026 rst during RUN SHALL abort the computation.
  - No done pulse is produced.
  - The outputs hold their reset values until a new computation completes.

Verification (NIB=4)
REQ-027 a=16'h1234, b=16'h4321, cin=0, start one cycle ->
  - busy high for 4 cycles, then done=1 for 1 cycle;
  - sum=16'h5555, cout=0, ovf=0.
REQ-028 a=16'h000F, b=16'h0001, cin=0 -> sum=16'h0010, cout=0 (inter-nibble carry).
  a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0.
REQ-029 a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
  a=16'h8000, b=16'h8000, cin=0 -> sum=16'h0000, cout=1, ovf=1.
REQ-030 Start a=16'h0001 + b=16'h0001; two cycles later pulse start with a=16'hFFFF, b=16'hFFFF ->
  - the second start is ignored;
  - sum=16'h0002, cout=0, done pulses once.
REQ-031 Run back-to-back: second start in the DONE cycle of the first ->
  - both done pulses occur, 5 cycles apart;
  - each result is correct.
REQ-032 Assert rst in the 2nd RUN cycle ->
  - busy=0 and done stays 0;
  - sum=0, cout=0, ovf=0;
  - a subsequent 16'h0003 + 16'h0004 yields sum=16'h0007.
